pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//   Hazard/sequencing controller for the 5-stage MIPS pipeline. Sits beside the datapath and drives the
//   enables, flushes and next-PC select of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//   Handles four cases: load-use stalls, taken beq/bne resolved in MEM, jumps decoded in ID, and
//   multi-cycle data-memory freezes. Also keeps saturating stall and flush counters for debug.
// PARAMETERS
//   MEM_WAIT  0   extra cycles a data-memory access holds the pipeline (0 = single-cycle DM)
//   CNT_W     16  width of the stall_cnt / flush_cnt counters
// PORTS
//   clk          in   1      pipeline clock; all state updates on posedge
//   rst_n        in   1      synchronous reset, active low
//   id_instru    in   32     instruction in IF/ID: [31:26] opcode, [25:21] rs, [20:16] rt
//   id_Jump      in   1      control Jump for the instruction in ID
//   ex_MemRead   in   1      MemRead of the instruction in ID/EX
//   ex_rt        in   5      rt field of the instruction in ID/EX (load destination)
//   mem_Branch   in   1      beq in EX/MEM
//   mem_Bne      in   1      bne in EX/MEM
//   mem_zero     in   1      ALU zero latched in EX/MEM
//   mem_access   in   1      MemRead|MemWrite of the instruction in EX/MEM
//   pc_write     out  1      PC load enable
//   ifid_write   out  1      IF/ID load enable
//   ifid_flush   out  1      IF/ID loads a nop
//   idex_bubble  out  1      ID/EX control bits cleared (bubble)
//   exmem_flush  out  1      EX/MEM control bits cleared
//   pipe_freeze  out  1      holds ID/EX, EX/MEM, MEM/WB and blocks DM/RF writes
//   pc_src       out  2      00 pc+4, 01 jump target, 10 branch target
//   state        out  2      current FSM state (debug)
//   stall_cnt    out  CNT_W  cycles with pc_write=0, saturating
//   flush_cnt    out  CNT_W  taken branches + jumps, saturating
// BEHAVIOUR
//   States: RUN, LU_STALL, MEM_WAIT. Control outputs are combinational from state + inputs.
//   While rst_n=0:
//     - pc_write=0, ifid_write=0; ifid_flush=idex_bubble=exmem_flush=1; pipe_freeze=0; pc_src=00.
//     - Next edge: state=RUN, counters=0, wait counter=0, served=0.
//     - Reset mid-freeze or mid-stall aborts it with no residue.
//   Term definitions:
//     - uses_rt  = opcode in {0x00 R-type, 0x04 beq, 0x05 bne, 0x2B sw}.
//     - lu_haz   = ex_MemRead & ex_rt!=0 & (ex_rt==rs | (uses_rt & ex_rt==rt)).
//     - br_taken = (mem_Branch & mem_zero) | (mem_Bne & ~mem_zero).
//     - mem_hold = (MEM_WAIT>0) & mem_access & ~served.
//   Priority per cycle (highest first): mem_hold/MEM_WAIT > br_taken > lu_haz > id_Jump > normal.
//     - Freeze: pipe_freeze=1, pc_write=0, ifid_write=0, no flushes.
//         RUN -> MEM_WAIT with wcnt=MEM_WAIT-1.
//         In MEM_WAIT: stay frozen, decrement wcnt; at wcnt=0 -> RUN and set served=1.
//         Total frozen cycles = MEM_WAIT. served clears on the next edge, so the same access
//         never re-freezes.
//     - Branch: pc_src=10, ifid_flush=1, idex_bubble=1, exmem_flush=1 (squash the 3 younger instrs).
//     - Load-use: pc_write=0, ifid_write=0, idex_bubble=1; RUN -> LU_STALL.
//         LU_STALL lasts exactly 1 cycle, then RUN. lu_haz is re-evaluated normally there.
//     - Jump: pc_src=01, ifid_flush=1. A jump blocked by a load-use stall is taken the next cycle.
//     - Normal: pc_write=ifid_write=1, everything else 0, pc_src=00.
//   Branch wins over a simultaneous load-use or jump; the younger ones are flushed.
//   Counters: +1 per edge as above; stick at all-ones; never wrap.
// STRUCTURE
//   pipe_ctrl_pkg: state enum, opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW),
//     PC_SRC_* encodings.
//   One sub-module hazard_detect: combinational lu_haz from id_instru/ex_MemRead/ex_rt.
//   FSM, wait counter and statistics counters stay in pipe_ctrl.
// TESTING
//   1 lw $2,0($1) in EX, add $3,$2,$4 in ID -> 1 cycle pc_write=0, idex_bubble=1; state RUN,LU_STALL,RUN;
//     stall_cnt=1.
//   2 lw to $0 in EX with a reader of $0 in ID -> no stall; addi reading rt=ex_rt -> no stall (uses_rt=0).
//   3 beq in MEM, mem_zero=1, same cycle lu_haz=1 and id_Jump=1 -> pc_src=10 and all three flushes=1;
//     flush_cnt+1; no stall.
//   4 bne in MEM with mem_zero=1 -> not taken, pc_src=00. Then j in ID -> pc_src=01, ifid_flush=1.
//   5 MEM_WAIT=3, sw in MEM -> pipe_freeze=1 for exactly 3 cycles, then 1 cycle advancing with
//     mem_access=1 and no refreeze. Repeat with rst_n=0 in the 2nd frozen cycle -> state RUN, counters 0.
//   6 Force 70000 load-use stalls, CNT_W=16 -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types and constants for the 5-stage pipeline hazard /
//          sequencing controller: FSM state encoding, MIPS opcodes and the
//          next-PC select encodings.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller FSM states. The encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } pipe_state_e;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    // Next-PC select encodings
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // pc + 4
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;  // jump target
    localparam logic [1:0] PC_SRC_BRANCH = 2'b10;  // branch target

    // Instructions whose rt field is a source operand. For I-type ALU ops
    // and loads rt is a destination, so matching it against a pending load
    // must not cause a stall.
    function automatic logic op_uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module : hazard_detect
// Brief  : Combinational load-use hazard detector. Flags when the
//          instruction in ID reads the register being loaded by the
//          instruction currently in EX.
// Ports  : id_instru   in  32  instruction in IF/ID
//          ex_MemRead  in  1   instruction in ID/EX is a load
//          ex_rt       in  5   load destination register in ID/EX
//          lu_haz      out 1   load-use hazard present
// Rev    : 1.0  initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] id_instru,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rt,
    output logic        lu_haz
);

    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_uses_rt;
    logic       w_unused_low;

    assign w_opcode  = id_instru[31:26];
    assign w_rs      = id_instru[25:21];
    assign w_rt      = id_instru[20:16];
    assign w_uses_rt = op_uses_rt(w_opcode);

    // Immediate / rd / funct bits play no part in hazard detection.
    assign w_unused_low = ^id_instru[15:0];

    // $0 is hard-wired to zero, so a load "into" it never creates a hazard.
    assign lu_haz = ex_MemRead && (ex_rt != 5'd0) &&
                    ((ex_rt == w_rs) || (w_uses_rt && (ex_rt == w_rt)));

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl
// Brief  : Hazard / sequencing controller for a 5-stage MIPS pipeline.
//          Drives PC and pipeline-register enables, flushes and next-PC
//          select. Handles data-memory freezes, taken branches resolved in
//          MEM, load-use stalls and jumps decoded in ID, in that priority.
//          Keeps saturating stall and flush counters for debug.
// Params : MEM_WAIT  extra cycles a data-memory access holds the pipeline
//          CNT_W     width of stall_cnt / flush_cnt
// Ports  : clk, rst_n (synchronous, active low)
//          id_instru, id_Jump                 ID-stage inputs
//          ex_MemRead, ex_rt                  EX-stage inputs
//          mem_Branch, mem_Bne, mem_zero,
//          mem_access                         MEM-stage inputs
//          pc_write, ifid_write, ifid_flush,
//          idex_bubble, exmem_flush,
//          pipe_freeze, pc_src                pipeline control outputs
//          state, stall_cnt, flush_cnt        debug outputs
// Rev    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instru,
    input  logic             id_Jump,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             mem_Branch,
    input  logic             mem_Bne,
    input  logic             mem_zero,
    input  logic             mem_access,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_freeze,
    output logic [1:0]       pc_src,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter holds at most MEM_WAIT-1.
    localparam int c_WCNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE  = c_WCNT_W'(1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_LOAD =
        c_WCNT_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

    pipe_state_e         r_state;
    pipe_state_e         w_next_state;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_WCNT_W-1:0] w_next_wcnt;
    logic                r_served;
    logic                w_next_served;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic w_lu_haz;
    logic w_br_taken;
    logic w_mem_hold;
    logic w_flush_evt;

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    hazard_detect u_hazard_detect (
        .id_instru  (id_instru),
        .ex_MemRead (ex_MemRead),
        .ex_rt      (ex_rt),
        .lu_haz     (w_lu_haz)
    );

    assign w_br_taken = (mem_Branch && mem_zero) || (mem_Bne && !mem_zero);

    // r_served marks the single cycle right after a freeze completes; the
    // access that caused the freeze is still in EX/MEM then and must be
    // allowed through rather than freezing again.
    assign w_mem_hold = (MEM_WAIT > 0) && mem_access && !r_served;

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_flush   = 1'b0;
        pipe_freeze   = 1'b0;
        pc_src        = PC_SRC_SEQ;
        w_next_state  = ST_RUN;
        w_next_wcnt   = r_wcnt;
        w_next_served = 1'b0;
        w_flush_evt   = 1'b0;

        if (!rst_n) begin
            // Hold the front end and flush everything while in reset.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (r_state == ST_MEM_WAIT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
            if (r_wcnt <= c_WCNT_ONE) begin
                w_next_state  = ST_RUN;
                w_next_served = 1'b1;
            end else begin
                w_next_state = ST_MEM_WAIT;
                w_next_wcnt  = r_wcnt - c_WCNT_ONE;
            end
        end else if (w_mem_hold) begin
            // First frozen cycle is spent in RUN/LU_STALL itself, so a
            // one-cycle wait never enters ST_MEM_WAIT at all.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
            if (MEM_WAIT == 1) begin
                w_next_served = 1'b1;
            end else begin
                w_next_state = ST_MEM_WAIT;
                w_next_wcnt  = c_WAIT_LOAD;
            end
        end else if (w_br_taken) begin
            // Squash the three younger instructions in IF/ID, ID/EX, EX/MEM.
            pc_src      = PC_SRC_BRANCH;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            w_flush_evt = 1'b1;
        end else if (w_lu_haz) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            w_next_state = ST_LU_STALL;
        end else if (id_Jump) begin
            pc_src      = PC_SRC_JUMP;
            ifid_flush  = 1'b1;
            w_flush_evt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State, wait counter and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_wcnt      <= '0;
            r_served    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_wcnt   <= w_next_wcnt;
            r_served <= w_next_served;
            if (!pc_write && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_ctrl
// Brief  : Self-checking bench for pipe_ctrl. Directed scenarios followed by
//          randomized traffic, all compared against a cycle-level
//          behavioural model of the controller's rules.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MEM_WAIT = 3;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      id_instru;
    logic             id_Jump;
    logic             ex_MemRead;
    logic [4:0]       ex_rt;
    logic             mem_Branch;
    logic             mem_Bne;
    logic             mem_zero;
    logic             mem_access;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic             pipe_freeze;
    logic [1:0]       pc_src;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_instru   (id_instru),
        .id_Jump     (id_Jump),
        .ex_MemRead  (ex_MemRead),
        .ex_rt       (ex_rt),
        .mem_Branch  (mem_Branch),
        .mem_Bne     (mem_Bne),
        .mem_zero    (mem_zero),
        .mem_access  (mem_access),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .exmem_flush (exmem_flush),
        .pipe_freeze (pipe_freeze),
        .pc_src      (pc_src),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frozen cycles still to come, whether the previous
    // cycle was a load-use stall, the one-cycle "already served" pass,
    // and plain integer event counts.
    // ------------------------------------------------------------------
    int m_freeze_left;
    bit m_prev_lu;
    bit m_served;
    int m_stall;
    int m_flush;

    bit last_freeze;

    function automatic logic [31:0] mk_instr(input logic [5:0] op, input int rs, input int rt);
        logic [31:0] v;
        v = {op, 5'(rs), 5'(rt), 16'h1234};
        return v;
    endfunction

    task automatic model_reset();
        m_freeze_left = 0;
        m_prev_lu     = 0;
        m_served      = 0;
        m_stall       = 0;
        m_flush       = 0;
    endtask

    task automatic step(input bit rst, input logic [31:0] ins, input bit jmp,
                        input bit mr, input int ert, input bit br, input bit bn,
                        input bit zr, input bit acc);
        logic [5:0] opc;
        int  rs, rt;
        bit  uses, haz, taken, frozen, jump_go, stall_go;
        logic [7:0] exp_ctl;
        logic [1:0] exp_state;

        @(negedge clk);
        rst_n      = rst;
        id_instru  = ins;
        id_Jump    = jmp;
        ex_MemRead = mr;
        ex_rt      = 5'(ert);
        mem_Branch = br;
        mem_Bne    = bn;
        mem_zero   = zr;
        mem_access = acc;
        #1;

        opc   = ins[31:26];
        rs    = int'(ins[25:21]);
        rt    = int'(ins[20:16]);
        uses  = (opc == 6'h00) || (opc == 6'h04) || (opc == 6'h05) || (opc == 6'h2B);
        haz   = mr && (ert != 0) && ((ert == rs) || (uses && ert == rt));
        taken = (br && zr) || (bn && !zr);
        frozen = (m_freeze_left > 0) || (MEM_WAIT > 0 && acc && !m_served);

        if (m_freeze_left > 0)      exp_state = ST_MEM_WAIT;
        else if (m_prev_lu)         exp_state = ST_LU_STALL;
        else                        exp_state = ST_RUN;

        jump_go  = 0;
        stall_go = 0;
        // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_freeze, pc_src}
        if (!rst)        exp_ctl = {6'b001110, 2'b00};
        else if (frozen) exp_ctl = {6'b000001, 2'b00};
        else if (taken)  exp_ctl = {6'b111110, 2'b10};
        else if (haz)  begin exp_ctl = {6'b000100, 2'b00}; stall_go = 1; end
        else if (jmp)  begin exp_ctl = {6'b111000, 2'b01}; jump_go = 1; end
        else             exp_ctl = {6'b110000, 2'b00};

        check_val("ctl", {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush,
                          pipe_freeze, pc_src}, exp_ctl);
        check_val("state", state, exp_state);
        check_val("stall_cnt", stall_cnt, m_stall);
        check_val("flush_cnt", flush_cnt, m_flush);
        last_freeze = pipe_freeze;

        // Advance the model across the coming edge.
        if (!rst) begin
            model_reset();
        end else begin
            if (!exp_ctl[7] && m_stall < CNT_MAX) m_stall++;
            if ((!frozen && taken) || jump_go) begin
                if (m_flush < CNT_MAX) m_flush++;
            end
            m_prev_lu = !frozen && !taken && stall_go;
            if (frozen) begin
                if (m_freeze_left > 0) m_freeze_left--;
                else                   m_freeze_left = MEM_WAIT - 1;
                m_served = (m_freeze_left == 0);
            end else begin
                m_served = 0;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(1, mk_instr(OP_RTYPE, 5, 6), 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [5:0] op_pool [7];
    int         freeze_seen;
    int         stall_before;

    initial begin
        op_pool = '{OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW, 6'h08, 6'h02};

        // Initial reset to bring the DUT out of X before checking anything.
        rst_n = 0; id_instru = '0; id_Jump = 0; ex_MemRead = 0; ex_rt = '0;
        mem_Branch = 0; mem_Bne = 0; mem_zero = 0; mem_access = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset outputs, then normal running.
        step(0, mk_instr(OP_RTYPE, 1, 2), 1, 1, 1, 1, 0, 1, 1);
        idle();
        idle();

        // 1: lw $2 in EX, add $3,$2,$4 in ID -> single stall cycle.
        stall_before = int'(stall_cnt);
        step(1, mk_instr(OP_RTYPE, 2, 4), 0, 1, 2, 0, 0, 0, 0);
        step(1, mk_instr(OP_RTYPE, 2, 4), 0, 0, 0, 0, 0, 0, 0);
        idle();
        check_val("lu_stall_delta", stall_cnt, 64'(stall_before + 1));

        // 2: lw to $0 with $0 reader; addi whose rt matches the load.
        step(1, mk_instr(OP_RTYPE, 0, 0), 0, 1, 0, 0, 0, 0, 0);
        step(1, mk_instr(6'h08, 1, 2), 0, 1, 2, 0, 0, 0, 0);

        // 3: taken beq with simultaneous load-use and jump.
        step(1, mk_instr(OP_RTYPE, 3, 1), 1, 1, 3, 1, 0, 1, 0);
        idle();

        // 4: bne not taken, then a jump.
        step(1, mk_instr(OP_RTYPE, 5, 6), 0, 0, 0, 0, 1, 1, 0);
        step(1, mk_instr(6'h02, 0, 0), 1, 0, 0, 0, 0, 0, 0);
        // Jump blocked by load-use, taken the cycle after.
        step(1, mk_instr(OP_RTYPE, 7, 1), 1, 1, 7, 0, 0, 0, 0);
        step(1, mk_instr(OP_RTYPE, 7, 1), 1, 0, 0, 0, 0, 0, 0);

        // 5: sw in MEM holds the pipe for MEM_WAIT cycles, then advances.
        freeze_seen = 0;
        for (int i = 0; i < MEM_WAIT + 1; i++) begin
            step(1, mk_instr(OP_SW, 1, 2), 0, 0, 0, 0, 0, 0, 1);
            if (last_freeze) freeze_seen++;
        end
        check_val("freeze_cycles", freeze_seen, MEM_WAIT);
        idle();
        // Reset during the 2nd frozen cycle aborts the freeze.
        step(1, mk_instr(OP_SW, 1, 2), 0, 0, 0, 0, 0, 0, 1);
        step(0, mk_instr(OP_SW, 1, 2), 0, 0, 0, 0, 0, 0, 1);
        idle();
        check_val("rst_state", state, ST_RUN);
        check_val("rst_stall_cnt", stall_cnt, 0);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            op = op_pool[$urandom_range(0, 6)];
            step(($urandom_range(0, 59) != 0),
                 mk_instr(op, $urandom_range(0, 3), $urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) || (op == 6'h02),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5) == 0);
        end

        // 6: sustained load-use stalls saturate stall_cnt.
        step(0, mk_instr(OP_RTYPE, 0, 0), 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) begin
            step(1, mk_instr(OP_RTYPE, 2, 4), 0, 1, 2, 0, 0, 0, 0);
        end
        idle();
        check_val("stall_sat", stall_cnt, 64'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
